// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: oversamples pins in clk, decodes a leading target byte and emits byte strobes.
// Start/strobe rises SYNC_STAGES+2 clk after the 8th sclk rise at the pin; no backpressure (MCU paces).
module mcu_spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TARGET_SYS  = 8'd1,
  parameter logic [7:0] TARGET_HID  = 8'd2,
  parameter logic [7:0] TARGET_OSD  = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       mcu_start,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic [7:0] mcu_data,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, mosi_sync;
  logic       csn_d, sclk_d;
  logic       csn_s, sclk_s, mosi_s;
  logic       sclk_rise, sclk_fall, csn_fall, shift_en;
  logic [2:0] bit_cnt;
  logic [7:0] rx, tx, target;
  logic       byte_done;
  logic [7:0] cur_target, reply;

  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign shift_en  = sclk_rise & ~csn_s & (state != IDLE);

  assign spi_miso = tx[7];

  // csn chain resets low so a pin already held low after reset never looks like a fresh fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_sync  <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_d     <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_d     <= csn_s;
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csn_fall) state_nxt = CMD;
      CMD:     if (csn_s) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (csn_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The target byte just completed in CMD already selects the reply for the next byte
  always_comb begin
    cur_target = (state == CMD) ? rx : target;
    reply      = 8'h00;
    case (cur_target)
      TARGET_SYS: reply = mcu_sys_din;
      TARGET_HID: reply = mcu_hid_din;
      TARGET_OSD: reply = mcu_osd_din;
      default:    reply = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt        <= 3'd0;
      rx             <= 8'h00;
      tx             <= 8'h00;
      target         <= 8'h00;
      byte_done      <= 1'b0;
      mcu_data       <= 8'h00;
      mcu_start      <= 1'b0;
      mcu_sys_strobe <= 1'b0;
      mcu_hid_strobe <= 1'b0;
      mcu_osd_strobe <= 1'b0;
    end else begin
      mcu_start      <= 1'b0;
      mcu_sys_strobe <= 1'b0;
      mcu_hid_strobe <= 1'b0;
      mcu_osd_strobe <= 1'b0;
      byte_done      <= shift_en && (bit_cnt == 3'd7);

      if (shift_en) begin
        rx      <= {rx[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (csn_s) begin
        bit_cnt <= 3'd0;
      end

      if (byte_done) begin
        mcu_data <= rx;
        if (state == CMD) begin
          target    <= rx;
          mcu_start <= 1'b1;
        end else if (state == DATA) begin
          mcu_sys_strobe <= (target == TARGET_SYS);
          mcu_hid_strobe <= (target == TARGET_HID);
          mcu_osd_strobe <= (target == TARGET_OSD);
        end
      end

      // Falling edge at count 0 is the trailing edge of a byte: keep the freshly loaded MSB
      if (csn_s || state == IDLE)
        tx <= 8'h00;
      else if (byte_done)
        tx <= reply;
      else if (sclk_fall && bit_cnt != 3'd0)
        tx <= {tx[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: table of whole transfers plus hand-written corner sequences.
module tb_mcu_spi_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_csn, spi_sclk, spi_mosi, spi_miso;
  logic       mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe;
  logic [7:0] mcu_data, mcu_sys_din, mcu_hid_din, mcu_osd_din;

  mcu_spi_target dut (
    .clk(clk), .reset(reset),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .mcu_start(mcu_start), .mcu_sys_strobe(mcu_sys_strobe),
    .mcu_hid_strobe(mcu_hid_strobe), .mcu_osd_strobe(mcu_osd_strobe),
    .mcu_data(mcu_data),
    .mcu_sys_din(mcu_sys_din), .mcu_hid_din(mcu_hid_din), .mcu_osd_din(mcu_osd_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event kinds: 0 start, 1 sys, 2 hid, 3 osd
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] dat;
    int         cyc;
  } ev_t;

  ev_t evq[$];
  int  multi_hi = 0;
  int  last_rise = 0;
  int  checks = 0;
  int  errors = 0;

  always @(negedge clk) begin
    if ($countones({mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe}) > 1)
      multi_hi <= multi_hi + 1;
    if (mcu_start)      evq.push_back({3'd0, mcu_data, cyc});
    if (mcu_sys_strobe) evq.push_back({3'd1, mcu_data, cyc});
    if (mcu_hid_strobe) evq.push_back({3'd2, mcu_data, cyc});
    if (mcu_osd_strobe) evq.push_back({3'd3, mcu_data, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sclk = clk/8: 4 clk low (MISO sampled just before the rise), 4 clk high
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      tick(4);
      r[i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 0) last_rise = cyc;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic xfer(input int n, input logic [3:0][7:0] txb, output logic [3:0][7:0] rxb);
    logic [7:0] r;
    rxb = '0;
    spi_csn = 1'b0;
    tick(4);
    for (int k = 0; k < n; k++) begin
      spi_bits(txb[k], 8, r);
      rxb[k] = r;
    end
    tick(4);
    spi_csn = 1'b1;
    tick(8);
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][7:0]  tx;      // tx[0] is the target byte
    logic [7:0]       sys_din, hid_din, osd_din;
    logic [2:0]       kind;    // expected strobe kind, 0 = none
    logic [3:0][7:0]  miso;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [3:0][7:0] got;
    logic [7:0]      r;
    int              nexp;

    vecs[0] = {3'd3, {8'h00, 8'h5A, 8'hA5, 8'h03}, 8'h00, 8'h00, 8'h77, 3'd3, {8'h00, 8'h77, 8'h77, 8'h00}};
    vecs[1] = {3'd3, {8'h00, 8'h00, 8'h00, 8'h01}, 8'hC3, 8'h00, 8'h00, 3'd1, {8'h00, 8'hC3, 8'hC3, 8'h00}};
    vecs[2] = {3'd2, {8'h00, 8'h00, 8'h11, 8'h02}, 8'h00, 8'h9E, 8'h00, 3'd2, {8'h00, 8'h00, 8'h9E, 8'h00}};
    vecs[3] = {3'd3, {8'h00, 8'h34, 8'h12, 8'h7F}, 8'hAA, 8'hBB, 8'hCC, 3'd0, {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[4] = {3'd4, {8'h01, 8'h80, 8'hFE, 8'h02}, 8'h00, 8'h5A, 8'h00, 3'd2, {8'h5A, 8'h5A, 8'h5A, 8'h00}};

    reset = 1'b1;
    spi_csn = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    mcu_sys_din = 8'h00; mcu_hid_din = 8'h00; mcu_osd_din = 8'h00;
    tick(3);
    check("reset_outputs", 32'({spi_miso, mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_data}), 32'h0);
    reset = 1'b0;
    tick(4);
    check("idle_outputs", 32'({spi_miso, mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_data}), 32'h0);

    for (int v = 0; v < 5; v++) begin
      evq.delete();
      mcu_sys_din = vecs[v].sys_din;
      mcu_hid_din = vecs[v].hid_din;
      mcu_osd_din = vecs[v].osd_din;
      xfer(int'(vecs[v].n), vecs[v].tx, got);
      for (int k = 0; k < int'(vecs[v].n); k++)
        check($sformatf("v%0d_miso%0d", v, k), 32'(got[k]), 32'(vecs[v].miso[k]));
      nexp = (vecs[v].kind != 3'd0) ? int'(vecs[v].n) : 1;
      check($sformatf("v%0d_events", v), 32'(evq.size()), 32'(nexp));
      if (evq.size() == nexp) begin
        check($sformatf("v%0d_start", v), 32'({evq[0].kind, evq[0].dat}), 32'({3'd0, vecs[v].tx[0]}));
        for (int k = 1; k < nexp; k++)
          check($sformatf("v%0d_strobe%0d", v, k), 32'({evq[k].kind, evq[k].dat}),
                32'({vecs[v].kind, vecs[v].tx[k]}));
        if (vecs[v].kind != 3'd0)
          check($sformatf("v%0d_latency", v), 32'(evq[nexp-1].cyc - last_rise), 32'd4);
      end
    end

    // Reply follows din sampled at the previous byte's completion
    evq.delete();
    mcu_sys_din = 8'hC3;
    spi_csn = 1'b0;
    tick(4);
    spi_bits(8'h01, 8, r);
    check("din_byte1", 32'(r), 32'h00);
    mcu_sys_din = 8'h3C;
    spi_bits(8'h00, 8, r);
    check("din_byte2", 32'(r), 32'hC3);
    spi_bits(8'h00, 8, r);
    check("din_byte3", 32'(r), 32'h3C);
    tick(4); spi_csn = 1'b1; tick(8);

    // csn high mid-byte drops the partial byte; next transfer restarts in CMD
    evq.delete();
    mcu_osd_din = 8'hFF;
    spi_csn = 1'b0;
    tick(4);
    spi_bits(8'h03, 8, r);
    spi_bits(8'hE7, 5, r);
    tick(4); spi_csn = 1'b1; tick(8);
    check("abort_events", 32'(evq.size()), 32'd1);
    check("abort_miso_idle", 32'(spi_miso), 32'd0);
    evq.delete();
    mcu_hid_din = 8'h00;
    xfer(2, {8'h00, 8'h00, 8'h11, 8'h02}, got);
    check("after_abort_events", 32'(evq.size()), 32'd2);
    if (evq.size() == 2) begin
      check("after_abort_start", 32'({evq[0].kind, evq[0].dat}), 32'({3'd0, 8'h02}));
      check("after_abort_hid", 32'({evq[1].kind, evq[1].dat}), 32'({3'd2, 8'h11}));
    end
    check("data_held", 32'(mcu_data), 32'h11);

    // csn rise together with the 8th sclk rise: byte dropped
    evq.delete();
    spi_csn = 1'b0;
    tick(4);
    spi_bits(8'h03, 8, r);
    spi_bits(8'hFE, 7, r);
    spi_mosi = 1'b1;
    tick(4);
    spi_sclk = 1'b1; spi_csn = 1'b1;
    tick(8);
    spi_sclk = 1'b0;
    tick(8);
    check("simul_events", 32'(evq.size()), 32'd1);

    // Reset during byte 2 of an OSD transfer
    evq.delete();
    mcu_osd_din = 8'hFF;
    spi_csn = 1'b0;
    tick(4);
    spi_bits(8'h03, 8, r);
    spi_bits(8'hA5, 4, r);
    check("pre_reset_miso", 32'(spi_miso), 32'd1);
    reset = 1'b1;
    tick(2);
    check("mid_reset_outputs", 32'({spi_miso, mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_data}), 32'h0);
    reset = 1'b0;
    spi_bits(8'h55, 4, r);
    spi_bits(8'h66, 8, r);
    tick(4); spi_csn = 1'b1; tick(8);
    check("post_reset_events", 32'(evq.size()), 32'd1);
    check("post_reset_data", 32'(mcu_data), 32'h00);

    // Back-to-back bytes at sclk = clk/8
    evq.delete();
    spi_csn = 1'b0;
    tick(4);
    spi_bits(8'h03, 8, r);
    for (int i = 0; i < 16; i++) spi_bits(8'(i), 8, r);
    tick(4); spi_csn = 1'b1; tick(8);
    check("b2b_events", 32'(evq.size()), 32'd17);
    if (evq.size() == 17)
      for (int i = 1; i <= 16; i++)
        check($sformatf("b2b_%0d", i), 32'({evq[i].kind, evq[i].dat}), 32'({3'd3, 8'(i - 1)}));

    check("one_hot_pulses", 32'(multi_hi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
